// File: rtl/seven_segment_scan_controller_pkg.sv
// Shared types and the hex glyph table for the seven-segment scan controller.
//   state_t    : scan FSM states (OFF, BLANK, SHOW)
//   seg_t      : segment bus {a,b,c,d,e,f,g,dp}, active-high
//   hex_to_seg : nibble -> glyph with dp cleared
package seven_segment_pkg;

   typedef enum logic [1:0] {OFF, BLANK, SHOW} state_t;

   typedef logic [7:0] seg_t;

   function automatic seg_t hex_to_seg(input logic [3:0] nibble);
      seg_t glyph;
      unique case (nibble)
         4'h0: glyph = 8'hFC;
         4'h1: glyph = 8'h60;
         4'h2: glyph = 8'hDA;
         4'h3: glyph = 8'hF2;
         4'h4: glyph = 8'h66;
         4'h5: glyph = 8'hB6;
         4'h6: glyph = 8'hBE;
         4'h7: glyph = 8'hE0;
         4'h8: glyph = 8'hFE;
         4'h9: glyph = 8'hF6;
         4'hA: glyph = 8'hEE;
         4'hB: glyph = 8'h3E;
         4'hC: glyph = 8'h9C;
         4'hD: glyph = 8'h7A;
         4'hE: glyph = 8'h9E;
         4'hF: glyph = 8'h8E;
         default: glyph = '0;
      endcase
      return glyph;
   endfunction

endpackage

// File: rtl/seven_segment_scan_controller_if.sv
// Load port of the scan controller: valid/ready handshake carrying new
// display contents.
//   load_valid : new contents offered (master -> slave)
//   load_ready : pending buffer empty (slave -> master)
//   load_data  : hex nibbles, digit i = load_data[4*i+3:4*i]
//   load_dp    : decimal points, bit i belongs to digit i
interface seven_segment_scan_controller_if #(
   parameter int unsigned n_digits = 4
);
   logic                    load_valid;
   logic                    load_ready;
   logic [4*n_digits-1:0]   load_data;
   logic [n_digits-1:0]     load_dp;

   modport master (output load_valid, output load_data, output load_dp,
                   input  load_ready);
   modport slave  (input  load_valid, input  load_data, input  load_dp,
                   output load_ready);
endinterface

// File: rtl/seven_segment_scan_controller_decoder.sv
// Combinational digit decoder: one hex nibble plus decimal point to a
// segment pattern.
//   nibble_i : hex value 0..F
//   dp_i     : decimal point
//   seg_o    : {a,b,c,d,e,f,g,dp}, active-high
module seven_segment_digit_decoder
   import seven_segment_pkg::*;
(
   input  logic [3:0] nibble_i,
   input  logic       dp_i,
   output seg_t       seg_o
);

   assign seg_o = hex_to_seg(nibble_i) | {7'b0, dp_i};

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Time-multiplexed seven-segment scan controller with blanking gaps and
// tear-free double buffering (pending contents swap in at frame boundaries).
//   clk, reset  : clock, synchronous active-high reset
//   load        : valid/ready load port (slave side)
//   digit_en    : live enable mask, sampled in OFF and at the end of a SHOW slot
//   seg         : registered segment bus {a..g,dp}
//   digit_sel   : registered one-hot digit select
//   frame_done  : 1-clk pulse at each frame boundary
module seven_segment_scan_controller
   import seven_segment_pkg::*;
#(
   parameter int unsigned n_digits     = 4,
   parameter int unsigned strobe_width = 20,
   parameter int unsigned blank_cycles = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   seven_segment_scan_controller_if.slave load,
   input  logic [n_digits-1:0]           digit_en,
   output seg_t                          seg,
   output logic [n_digits-1:0]           digit_sel,
   output logic                          frame_done
);

   localparam int unsigned IW = $clog2(n_digits);
   localparam int unsigned CW = strobe_width + $clog2(blank_cycles) + 1;
   localparam logic [CW-1:0] SHOW_LAST  = CW'((2**strobe_width) - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(blank_cycles - 1);
   localparam logic [n_digits-1:0] SEL_ONE = {{(n_digits-1){1'b0}}, 1'b1};

   state_t                state_q, state_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  pending_full_q, pending_full_d;
   logic [4*n_digits-1:0] pending_data_q, pending_data_d;
   logic [n_digits-1:0]   pending_dp_q, pending_dp_d;
   logic [4*n_digits-1:0] shadow_data_q, shadow_data_d;
   logic [n_digits-1:0]   shadow_dp_q, shadow_dp_d;
   seg_t                  seg_q, seg_d;
   logic [n_digits-1:0]   digit_sel_q, digit_sel_d;
   logic                  frame_done_q, frame_done_d;

   logic [IW-1:0]         first_idx, nxt_idx;
   logic                  boundary;
   seg_t                  dec_seg;

   // Priority searches: loops run high-to-low so the smallest offset wins.
   always_comb begin
      first_idx = '0;
      nxt_idx   = idx_q;
      for (int unsigned k = n_digits; k > 0; k--) begin
         if (digit_en[IW'(k - 1)]) first_idx = IW'(k - 1);
         if (digit_en[IW'((idx_q + k) % n_digits)]) nxt_idx = IW'((idx_q + k) % n_digits);
      end
   end

   // State register (plus datapath and output registers)
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= OFF;
         idx_q          <= '0;
         cnt_q          <= '0;
         pending_full_q <= 1'b0;
         pending_data_q <= '0;
         pending_dp_q   <= '0;
         shadow_data_q  <= '0;
         shadow_dp_q    <= '0;
         seg_q          <= '0;
         digit_sel_q    <= '0;
         frame_done_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         cnt_q          <= cnt_d;
         pending_full_q <= pending_full_d;
         pending_data_q <= pending_data_d;
         pending_dp_q   <= pending_dp_d;
         shadow_data_q  <= shadow_data_d;
         shadow_dp_q    <= shadow_dp_d;
         seg_q          <= seg_d;
         digit_sel_q    <= digit_sel_d;
         frame_done_q   <= frame_done_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      boundary = 1'b0;
      unique case (state_q)
         OFF: begin
            if (digit_en != '0) begin
               state_d  = BLANK;
               idx_d    = first_idx;
               cnt_d    = '0;
               boundary = 1'b1;
            end
         end
         BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               state_d = SHOW;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SHOW: begin
            if (cnt_q == SHOW_LAST) begin
               cnt_d = '0;
               if (digit_en == '0) begin
                  state_d = OFF;
               end else begin
                  state_d  = BLANK;
                  idx_d    = nxt_idx;
                  // Wrapping back (or a lone enabled digit) closes the frame.
                  boundary = (nxt_idx <= idx_q);
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = OFF;
      endcase
   end

   // Buffers: swap needs full, accept needs empty, so they never collide.
   always_comb begin
      pending_full_d = pending_full_q;
      pending_data_d = pending_data_q;
      pending_dp_d   = pending_dp_q;
      shadow_data_d  = shadow_data_q;
      shadow_dp_d    = shadow_dp_q;
      if (boundary && pending_full_q) begin
         shadow_data_d  = pending_data_q;
         shadow_dp_d    = pending_dp_q;
         pending_full_d = 1'b0;
      end
      if (load.load_valid && !pending_full_q) begin
         pending_data_d = load.load_data;
         pending_dp_d   = load.load_dp;
         pending_full_d = 1'b1;
      end
   end

   // Shadow only changes when entering BLANK, so it is stable for SHOW.
   seven_segment_digit_decoder u_decoder (
      .nibble_i (shadow_data_q[4*idx_d +: 4]),
      .dp_i     (shadow_dp_q[idx_d]),
      .seg_o    (dec_seg)
   );

   // Output logic: computed from the next state so digit_sel is valid on
   // the first SHOW clock.
   always_comb begin
      seg_d        = '0;
      digit_sel_d  = '0;
      frame_done_d = boundary;
      if (state_d == SHOW) begin
         seg_d       = dec_seg;
         digit_sel_d = SEL_ONE << idx_d;
      end
   end

   assign seg             = seg_q;
   assign digit_sel       = digit_sel_q;
   assign frame_done      = frame_done_q;
   assign load.load_ready = ~pending_full_q;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Directed bench for seven_segment_scan_controller with n_digits=4,
// strobe_width=1, blank_cycles=1: each slot is 1 BLANK clk + 2 SHOW clks.
// Tick t counts clocks after reset release; t=1 is the first BLANK.
module tb_seven_segment_scan_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] digit_en = '0;
   logic [7:0] seg;
   logic [3:0] digit_sel;
   logic       frame_done;
   int         errors = 0;
   int         checks = 0;

   seven_segment_scan_controller_if #(.n_digits(4)) load_if ();

   seven_segment_scan_controller #(
      .n_digits(4), .strobe_width(1), .blank_cycles(1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load_if),
      .digit_en   (digit_en),
      .seg        (seg),
      .digit_sel  (digit_sel),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      load_if.load_valid = 1'b0;
      load_if.load_data  = '0;
      load_if.load_dp    = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      digit_en = 4'b1111;
      do_reset();
      checks++;
      if ({digit_sel, seg, frame_done, load_if.load_ready} !== {4'b0, 8'h00, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset: sel=%b seg=%h fd=%b rdy=%b, required sel=0000 seg=00 fd=0 rdy=1",
                  digit_sel, seg, frame_done, load_if.load_ready);
      end
   endtask

   task automatic test_scan_default();
      logic [3:0] es; logic [7:0] eg; logic ef;
      digit_en = 4'b1111;
      do_reset();
      for (int t = 1; t <= 25; t++) begin
         int ph, s;
         tick();
         ph = (t - 1) % 3;
         s  = ((t - 1) / 3) % 4;
         es = (ph == 0) ? 4'b0000 : 4'(1 << s);
         eg = (ph == 0) ? 8'h00 : 8'hFC;
         ef = (ph == 0) && (s == 0);
         checks++;
         if ({digit_sel, seg, frame_done, load_if.load_ready} !== {es, eg, ef, 1'b1}) begin
            errors++;
            $display("FAIL scan t=%0d: sel=%b seg=%h fd=%b rdy=%b, required sel=%b seg=%h fd=%b rdy=1",
                     t, digit_sel, seg, frame_done, load_if.load_ready, es, eg, ef);
         end
      end
   endtask

   task automatic test_load_swap();
      logic [7:0] new_g [4];
      logic [3:0] es; logic [7:0] eg; logic ef, er;
      new_g = '{8'h66, 8'hF2, 8'hDA, 8'h60};
      digit_en = 4'b1111;
      do_reset();
      for (int t = 1; t <= 25; t++) begin
         int ph, s, fr;
         if (t == 5) begin
            load_if.load_valid = 1'b1;
            load_if.load_data  = 16'h1234;
            load_if.load_dp    = 4'b0000;
         end
         tick();
         load_if.load_valid = 1'b0;
         ph = (t - 1) % 3;
         s  = ((t - 1) / 3) % 4;
         fr = (t - 1) / 12;
         es = (ph == 0) ? 4'b0000 : 4'(1 << s);
         eg = (ph == 0) ? 8'h00 : ((fr == 0) ? 8'hFC : new_g[s]);
         ef = (ph == 0) && (s == 0);
         er = !(t >= 5 && t <= 12);
         checks++;
         if ({digit_sel, seg, frame_done, load_if.load_ready} !== {es, eg, ef, er}) begin
            errors++;
            $display("FAIL load_swap t=%0d: sel=%b seg=%h fd=%b rdy=%b, required sel=%b seg=%h fd=%b rdy=%b",
                     t, digit_sel, seg, frame_done, load_if.load_ready, es, eg, ef, er);
         end
      end
   endtask

   task automatic test_sparse_enable();
      logic [3:0]  sel_tab [16];
      logic [15:0] fd_tab;
      logic [7:0]  eg;
      sel_tab = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0001,
                  4'b0001, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
      fd_tab  = 16'h9041;
      digit_en = 4'b0101;
      do_reset();
      for (int t = 1; t <= 16; t++) begin
         if (t == 8) digit_en = 4'b1000;
         tick();
         eg = (sel_tab[t-1] != 4'b0000) ? 8'hFC : 8'h00;
         checks++;
         if ({digit_sel, seg, frame_done} !== {sel_tab[t-1], eg, fd_tab[t-1]}) begin
            errors++;
            $display("FAIL sparse_enable t=%0d: sel=%b seg=%h fd=%b, required sel=%b seg=%h fd=%b",
                     t, digit_sel, seg, frame_done, sel_tab[t-1], eg, fd_tab[t-1]);
         end
      end
   endtask

   task automatic test_disable_enable();
      logic [3:0] sel_tab [9];
      logic [8:0] fd_tab;
      logic [7:0] eg;
      sel_tab = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010};
      fd_tab  = 9'h041;
      digit_en = 4'b1111;
      do_reset();
      for (int t = 1; t <= 9; t++) begin
         if (t == 3) digit_en = 4'b0000;
         if (t == 7) digit_en = 4'b0010;
         tick();
         eg = (sel_tab[t-1] != 4'b0000) ? 8'hFC : 8'h00;
         checks++;
         if ({digit_sel, seg, frame_done, load_if.load_ready} !== {sel_tab[t-1], eg, fd_tab[t-1], 1'b1}) begin
            errors++;
            $display("FAIL disable_enable t=%0d: sel=%b seg=%h fd=%b rdy=%b, required sel=%b seg=%h fd=%b rdy=1",
                     t, digit_sel, seg, frame_done, load_if.load_ready, sel_tab[t-1], eg, fd_tab[t-1]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] a_g [4];
      logic [7:0] b_g [4];
      logic [3:0] es; logic [7:0] eg; logic ef, er;
      a_g = '{8'h60, 8'hDA, 8'hF2, 8'h66};   // 16'h4321
      b_g = '{8'hFF, 8'h8E, 8'hFD, 8'h8E};   // 16'hF0F8, dp 0101
      digit_en = 4'b1111;
      do_reset();
      for (int t = 1; t <= 36; t++) begin
         int ph, s, fr;
         if (t == 2) begin
            load_if.load_valid = 1'b1;
            load_if.load_data  = 16'h4321;
            load_if.load_dp    = 4'b0000;
         end
         if (t == 3) begin
            load_if.load_data = 16'hF0F8;
            load_if.load_dp   = 4'b0101;
         end
         if (t == 15) load_if.load_valid = 1'b0;
         tick();
         ph = (t - 1) % 3;
         s  = ((t - 1) / 3) % 4;
         fr = (t - 1) / 12;
         es = (ph == 0) ? 4'b0000 : 4'(1 << s);
         eg = (ph == 0) ? 8'h00 : ((fr == 0) ? 8'hFC : ((fr == 1) ? a_g[s] : b_g[s]));
         ef = (ph == 0) && (s == 0);
         er = !((t >= 2 && t <= 12) || (t >= 14 && t <= 24));
         checks++;
         if ({digit_sel, seg, frame_done, load_if.load_ready} !== {es, eg, ef, er}) begin
            errors++;
            $display("FAIL back_to_back t=%0d: sel=%b seg=%h fd=%b rdy=%b, required sel=%b seg=%h fd=%b rdy=%b",
                     t, digit_sel, seg, frame_done, load_if.load_ready, es, eg, ef, er);
         end
      end
   endtask

   task automatic test_reset_mid_show();
      logic [3:0] es; logic [7:0] eg; logic ef;
      digit_en = 4'b1111;
      do_reset();
      tick();
      load_if.load_valid = 1'b1;
      load_if.load_data  = 16'h9999;
      load_if.load_dp    = 4'b1111;
      tick();
      checks++;
      if ({digit_sel, seg, load_if.load_ready} !== {4'b0001, 8'hFC, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid pre: sel=%b seg=%h rdy=%b, required sel=0001 seg=fc rdy=0",
                  digit_sel, seg, load_if.load_ready);
      end
      load_if.load_valid = 1'b0;
      reset = 1'b1;
      tick();
      checks++;
      if ({digit_sel, seg, frame_done, load_if.load_ready} !== {4'b0, 8'h00, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_mid: sel=%b seg=%h fd=%b rdy=%b, required sel=0000 seg=00 fd=0 rdy=1",
                  digit_sel, seg, frame_done, load_if.load_ready);
      end
      reset = 1'b0;
      for (int t = 1; t <= 25; t++) begin
         int ph, s;
         tick();
         ph = (t - 1) % 3;
         s  = ((t - 1) / 3) % 4;
         es = (ph == 0) ? 4'b0000 : 4'(1 << s);
         eg = (ph == 0) ? 8'h00 : 8'hFC;
         ef = (ph == 0) && (s == 0);
         checks++;
         if ({digit_sel, seg, frame_done, load_if.load_ready} !== {es, eg, ef, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_after t=%0d: sel=%b seg=%h fd=%b rdy=%b, required sel=%b seg=%h fd=%b rdy=1",
                     t, digit_sel, seg, frame_done, load_if.load_ready, es, eg, ef);
         end
      end
   endtask

   initial begin
      load_if.load_valid = 1'b0;
      load_if.load_data  = '0;
      load_if.load_dp    = '0;
      test_reset();
      test_scan_default();
      test_load_swap();
      test_sparse_enable();
      test_disable_enable();
      test_back_to_back();
      test_reset_mid_show();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
